// File: rtl/demux1x2_stream.sv
// rtl/demux1x2_stream.sv - registered 1-to-2 stream demultiplexer with per-channel transfer counters
module demux1x2_stream #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_sel,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] y0_data,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] y1_data,
  output logic             y1_valid,
  input  logic             y1_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_st0;
  state_t           r_st1;
  state_t           w_nst0;
  state_t           w_nst1;
  logic [WIDTH-1:0] r_data0;
  logic [WIDTH-1:0] r_data1;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic             w_accept;
  logic             w_load0;
  logic             w_load1;
  logic             w_drain0;
  logic             w_drain1;

  // Only the addressed channel gates the input, so a stalled channel never blocks the other one.
  assign i_ready  = i_sel ? (~y1_valid | y1_ready) : (~y0_valid | y0_ready);
  // i_valid masks i_sel, so an unknown select while idle cannot load either channel.
  assign w_accept = i_valid & i_ready;
  assign w_load0  = w_accept & ~i_sel;
  assign w_load1  = w_accept & i_sel;
  assign w_drain0 = y0_valid & y0_ready;
  assign w_drain1 = y1_valid & y1_ready;

  assign y0_valid = (r_st0 == S_FULL);
  assign y1_valid = (r_st1 == S_FULL);
  assign y0_data  = r_data0;
  assign y1_data  = r_data1;
  assign cnt0     = r_cnt0;
  assign cnt1     = r_cnt1;

  // Channel occupancy state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st0 <= S_EMPTY;
      r_st1 <= S_EMPTY;
    end else begin
      r_st0 <= w_nst0;
      r_st1 <= w_nst1;
    end
  end

  // Next occupancy: a load always leaves the channel full, a drain without a load empties it.
  always_comb begin
    w_nst0 = r_st0;
    w_nst1 = r_st1;
    case (r_st0)
      S_EMPTY: if (w_load0) w_nst0 = S_FULL;
      S_FULL:  if (w_drain0 && !w_load0) w_nst0 = S_EMPTY;
      default: w_nst0 = S_EMPTY;
    endcase
    case (r_st1)
      S_EMPTY: if (w_load1) w_nst1 = S_FULL;
      S_FULL:  if (w_drain1 && !w_load1) w_nst1 = S_EMPTY;
      default: w_nst1 = S_EMPTY;
    endcase
  end

  // Holding registers change only on a load, which keeps data stable while a sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data0 <= '0;
      r_data1 <= '0;
    end else begin
      if (w_load0) r_data0 <= i_data;
      if (w_load1) r_data1 <= i_data;
    end
  end

  // Wrapping per-channel accept counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (clr_cnt) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_load0) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_load1) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux1x2_stream.sv
// tb/tb_demux1x2_stream.sv - randomized scoreboard bench for demux1x2_stream
module tb_demux1x2_stream;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] i_data;
  logic             i_sel;
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] y0_data;
  logic             y0_valid;
  logic             y0_ready;
  logic [WIDTH-1:0] y1_data;
  logic             y1_valid;
  logic             y1_ready;
  logic             clr_cnt;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  demux1x2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_data(i_data), .i_sel(i_sel), .i_valid(i_valid), .i_ready(i_ready),
    .y0_data(y0_data), .y0_valid(y0_valid), .y0_ready(y0_ready),
    .y1_data(y1_data), .y1_valid(y1_valid), .y1_ready(y1_ready),
    .clr_cnt(clr_cnt), .cnt0(cnt0), .cnt1(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model: words waiting in each channel's holding slot, and accept tallies.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;
  int acc0_total = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare what each channel presents against the model, and retire drained words.
  always @(negedge clk) begin
    if (mon_en) begin
      check("y0_valid", int'(y0_valid), int'(q0.size() != 0));
      if (y0_valid && q0.size() != 0) begin
        check("y0_data", int'(y0_data), int'(q0[0]));
        if (y0_ready) void'(q0.pop_front());
      end
      check("y1_valid", int'(y1_valid), int'(q1.size() != 0));
      if (y1_valid && q1.size() != 0) begin
        check("y1_data", int'(y1_data), int'(q1[0]));
        if (y1_ready) void'(q1.pop_front());
      end
      check("cnt0", int'(cnt0), exp_cnt0);
      check("cnt1", int'(cnt1), exp_cnt1);
    end
  end

  task automatic drive_random(input int valid_pct, input int clr_div);
    i_valid  = ($urandom_range(99) < valid_pct);
    i_sel    = $urandom_range(1);
    i_data   = WIDTH'($urandom);
    y0_ready = ($urandom_range(3) != 0);
    y1_ready = ($urandom_range(2) != 0);
    clr_cnt  = (clr_div != 0) && ($urandom_range(clr_div - 1) == 0);
  endtask

  // Model step for the coming edge: runs after the monitor has retired this cycle's drains.
  task automatic model_step();
    bit exp_rdy;
    bit acc;
    exp_rdy = i_sel ? (q1.size() == 0 || y1_ready) : (q0.size() == 0 || y0_ready);
    if (i_valid) check("i_ready", int'(i_ready), int'(exp_rdy));
    acc = i_valid && exp_rdy;
    if (acc) begin
      if (i_sel) q1.push_back(i_data);
      else begin
        q0.push_back(i_data);
        acc0_total++;
      end
    end
    if (clr_cnt) begin
      exp_cnt0 = 0;
      exp_cnt1 = 0;
    end else if (acc) begin
      if (i_sel) exp_cnt1 = (exp_cnt1 + 1) % CNT_MOD;
      else       exp_cnt0 = (exp_cnt0 + 1) % CNT_MOD;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0; i_sel = 1'b0; i_data = '0;
    y0_ready = 1'b0; y1_ready = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_y0_valid", int'(y0_valid), 0);
    check("rst_y1_valid", int'(y1_valid), 0);
    check("rst_y0_data", int'(y0_data), 0);
    check("rst_y1_data", int'(y1_data), 0);
    check("rst_cnt0", int'(cnt0), 0);
    check("rst_cnt1", int'(cnt1), 0);
    check("rst_i_ready", int'(i_ready), 1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    mon_en = 1'b1;

    // Phase 1: heavy traffic, no clears, so channel 0 runs its counter past a wrap.
    for (int c = 0; c < 1500; c++) begin
      #1 drive_random(85, 0);
      @(negedge clk); #1 model_step();
      @(posedge clk);
    end
    check("cnt0_wrapped", int'(acc0_total >= CNT_MOD), 1);

    // Phase 2: mixed traffic with occasional clears colliding with accepts.
    for (int c = 0; c < 1500; c++) begin
      #1 drive_random(60, 12);
      @(negedge clk); #1 model_step();
      @(posedge clk);
    end

    // Empty channel 1, then park a word there with its sink stalled.
    #1 i_valid = 1'b0; clr_cnt = 1'b0; y0_ready = 1'b1; y1_ready = 1'b1;
    @(negedge clk); #1 model_step();
    @(posedge clk);
    #1 i_valid = 1'b1; i_sel = 1'b1; i_data = 4'b0101; y1_ready = 1'b0;
    @(negedge clk); #1 model_step();
    @(posedge clk);
    #1 i_valid = 1'b0;
    mon_en = 1'b0;
    check("park_y1_valid", int'(y1_valid), 1);
    check("park_y1_data", int'(y1_data), 5);

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("async_y1_valid", int'(y1_valid), 0);
    check("async_y0_valid", int'(y0_valid), 0);
    check("async_cnt0", int'(cnt0), 0);
    check("async_cnt1", int'(cnt1), 0);
    check("async_i_ready", int'(i_ready), 1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_i_ready", int'(i_ready), 1);
    check("post_rst_y1_valid", int'(y1_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
